// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

endpackage

// File: rtl/div_step.sv
// One restoring-division stage: shift in a dividend bit, trial-subtract, restore on borrow.
// Purely combinational; the compare is WIDTH+1 bits so the shifted-out remainder MSB counts.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted_w;

  assign shifted_w = {rem_i, bit_i};
  assign q_o       = (shifted_w >= {1'b0, div_i});
  // When the subtraction succeeds the result is below the divisor, so WIDTH bits suffice.
  assign rem_o     = q_o ? WIDTH'(shifted_w - {1'b0, div_i}) : shifted_w[WIDTH-1:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider: one shared div_step reused for WIDTH cycles.
// Start/done handshake; results are registered and held until the next accepted start.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] resto,
  output logic             r_exists,
  output logic             erro
);

  div_state_t       state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] qreg_q;
  logic [WIDTH-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] resto_q;
  logic             rex_q;
  logic             erro_q;

  logic [WIDTH-1:0] acc_d;
  logic             qbit_d;
  logic [WIDTH-1:0] qreg_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (acc_q),
    .bit_i (qreg_q[WIDTH-1]),
    .div_i (div_q),
    .rem_o (acc_d),
    .q_o   (qbit_d)
  );

  assign qreg_d = {qreg_q[WIDTH-2:0], qbit_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      qreg_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      resto_q <= '0;
      rex_q   <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (b == '0) begin
              // Zero divisor skips RUN and overwrites the result registers at once.
              state_q <= DONE;
              done_q  <= 1'b1;
              s_q     <= '0;
              resto_q <= '0;
              rex_q   <= 1'b0;
              erro_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              acc_q   <= '0;
              qreg_q  <= a;
              div_q   <= b;
              cnt_q   <= CNT_W'(WIDTH);
              erro_q  <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          qreg_q <= qreg_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            s_q     <= qreg_d;
            resto_q <= acc_d;
            rex_q   <= |acc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign s        = s_q;
  assign resto    = resto_q;
  assign r_exists = rex_q;
  assign erro     = erro_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: vector table, corner sequences and random ops.
module tb_div_seq_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         rex;
    logic         err;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, r_exists, erro;
  logic [W-1:0] s, resto;

  div_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .resto(resto),
    .r_exists(r_exists), .erro(erro)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_push = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    vec_t v;
    v.a = ta;
    v.b = tb_v;
    if (tb_v == 0) begin
      v.s = 0; v.r = 0; v.rex = 0; v.err = 1;
    end else begin
      v.s = ta / tb_v; v.r = ta % tb_v; v.rex = (v.r != 0); v.err = 0;
    end
    return v;
  endfunction

  // Scoreboard side: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      vec_t e;
      n_done++;
      chk("done_single_pulse", prev_done, 0);
      chk("busy_with_done", busy, 0);
      if (sb.size() == 0) begin
        chk("done_without_request", done, 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", s, e.s);
        chk("remainder", resto, e.r);
        chk("r_exists", r_exists, e.rex);
        chk("erro", erro, e.err);
      end
    end
    prev_done = done;
  end

  task automatic launch(input vec_t v);
    @(negedge clk);
    a = v.a;
    b = v.b;
    start = 1'b1;
    sb.push_back(v);
    n_push++;
  endtask

  // Returns edge count to done, counting the accept edge as 1, and cycles with busy high.
  task automatic wait_done(output int lat, output int bcnt);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("done_seen", done, 1);
  endtask

  vec_t tbl[10];

  initial begin
    int lat, bc, guard;
    vec_t v;

    tbl[0] = '{a:100, b:7,   s:14,  r:2,   rex:1, err:0};
    tbl[1] = '{a:200, b:0,   s:0,   r:0,   rex:0, err:1};
    tbl[2] = '{a:255, b:1,   s:255, r:0,   rex:0, err:0};
    tbl[3] = '{a:5,   b:9,   s:0,   r:5,   rex:1, err:0};
    tbl[4] = '{a:200, b:130, s:1,   r:70,  rex:1, err:0};
    tbl[5] = '{a:0,   b:3,   s:0,   r:0,   rex:0, err:0};
    tbl[6] = '{a:255, b:255, s:1,   r:0,   rex:0, err:0};
    tbl[7] = '{a:255, b:128, s:1,   r:127, rex:1, err:0};
    tbl[8] = '{a:129, b:200, s:0,   r:129, rex:1, err:0};
    tbl[9] = '{a:254, b:127, s:2,   r:0,   rex:0, err:0};

    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_s", s, 0);
    chk("reset_resto", resto, 0);
    chk("reset_rex", r_exists, 0);
    chk("reset_erro", erro, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      launch(tbl[i]);
      wait_done(lat, bc);
      chk("latency", lat, (tbl[i].b == 0) ? 1 : W + 1);
      chk("busy_cycles", bc, (tbl[i].b == 0) ? 0 : W);
    end

    // Start during RUN is ignored; start in the DONE cycle is accepted.
    launch(model(100, 7));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 50; b = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 0; b = 0;
    guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("b2b_first_done", done, 1);
    a = 50; b = 5; start = 1'b1;
    v = model(50, 5);
    sb.push_back(v);
    n_push++;
    wait_done(lat, bc);
    chk("b2b_latency", lat, W + 1);

    // Reset mid-RUN aborts without a done pulse.
    launch(model(100, 7));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_s", s, 0);
    chk("abort_resto", resto, 0);
    chk("abort_rex", r_exists, 0);
    chk("abort_erro", erro, 0);
    void'(sb.pop_back());
    n_push--;
    repeat (2) @(negedge clk);
    chk("abort_no_done", done, 0);
    rst_n = 1'b1;
    launch(model(9, 3));
    wait_done(lat, bc);
    chk("post_reset_latency", lat, W + 1);

    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(1, 255));
      launch(model(ra, rb));
      wait_done(lat, bc);
    end

    repeat (3) @(negedge clk);
    chk("done_count", n_done, n_push);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
